seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for the clock/watch designs. It replaces the external select/enable sequencing with an internal scan counter and a blink timer. It also adds double-buffered display data, per-digit blink masking, decimal points and leading-zero blanking. It sits between the time-keeping logic and the board's segment/digit pins.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8).
SCAN_DIV, 50000, clk cycles each digit is driven per scan slot (>=2).
BLINK_DIV, 12500000, clk cycles per blink half-period (>=2).
DIG_ACTIVE_HIGH, 1, 1: dig bit high enables a digit; 0: inverted.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
data_in  input  4*DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) belongs to digit i; digit 0 is least significant
dp_in  input  DIGITS  decimal point request per digit, 1 = lit
blink_mask  input  DIGITS  1 = digit i blinks
lz_blank_en  input  1  1 = leading-zero blanking enabled
load  input  1  capture data_in/dp_in into pending buffer
dig  output  DIGITS  digit enables, registered
smg  output  8  segments, registered, active-low, bit0..7 = G F E D C B A P
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset: dig = all inactive; smg = 8'hFF; frame_done = 0; scan counter, digit index, blink counter = 0; blink phase = on; pending and display buffers = 0; pending_valid = 0.
- load = 1 on a clk edge: pending <= {data_in, dp_in}; pending_valid <= 1. Repeated loads overwrite; the last one before a frame boundary wins.
- Scan counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances. Index wraps from DIGITS-1 to 0.
- Frame boundary is a wrap of the index from DIGITS-1 to 0. In that cycle:
  - frame_done = 1.
  - If pending_valid, display <= pending and pending_valid <= 0.
  - If load is asserted in the same cycle, the new data goes to pending, pending_valid stays 1, and the transfer uses the old pending contents.
  - Displayed data therefore never changes mid-frame.
- Blink counter counts 0..BLINK_DIV-1 independently of the scan counter. At wrap, blink phase toggles.
- Output registers update every cycle from the current index, so outputs lag the index by 1 cycle.
  - dig: one-hot at bit [index] (inverted if DIG_ACTIVE_HIGH = 0).
  - If blink_mask[index] = 1 and blink phase = off, dig = all inactive and smg = 8'hFF for that slot.
- Segment encode, with P = ~dp (bit7):
  - 0 → 000_0001, 1 → 100_1111, 2 → 001_0010, 3 → 000_0110, 4 → 100_1100
  - 5 → 010_0100, 6 → 010_0000, 7 → 000_1111, 8 → 000_0000, 9 → 000_0100
  - Values 10..15 give segments all off (7'h7F); P still follows dp.
- Leading-zero blanking (lz_blank_en = 1):
  - Digit i is blanked (smg = 8'hFF, dp suppressed) if every display nibble from DIGITS-1 down to i equals 0, and i != 0.
  - Digit 0 is never blanked.
  - A nonzero nibble above i disables blanking for i.
  - The dig enable is still driven for blanked digits.
- Blink takes precedence over blanking. Blanking takes precedence over decode.
- rst asserted mid-frame: all state returns to reset values on that edge; the scan restarts at digit 0. Pending data is lost.

Test Plan:
- Reset: rst high for 3 cycles, then low → dig = 0000, smg = 8'hFF during reset; the first cycle after release still shows dig = 0000. The next cycle shows dig = 0001 with smg = decode(0) = 8'b1000_0001.
- Scan order (SCAN_DIV = 4, DIGITS = 4): load data_in = 16'h1234, wait one frame → digit 3..0 nibbles show 1, 2, 3, 4. Checks:
  - dig steps 0001 → 0010 → 0100 → 1000, each held 4 cycles.
  - digit 0 shows smg = 8'b1100_1100, digit 3 shows 8'b1100_1111.
  - frame_done pulses once per 16 cycles.
- Double-buffer: assert load with 16'h5678 mid-frame → the current frame still shows 1234; the frame after the next frame_done shows 5678.
  - Two loads in one frame → only the second value is displayed.
- Leading zeros: data 16'h0040, lz_blank_en = 1 → digits 3 and 2 show smg = 8'hFF; digit 1 shows "4"; digit 0 shows "0" (8'b1000_0001).
  - Data 16'h0000 → only digit 0 is lit.
  - lz_blank_en = 0 → all four digits show "0".
- Blink (BLINK_DIV = 8): blink_mask = 4'b0100 → during the off phase, digit 2's slot drives dig = 0000 and smg = 8'hFF; other digits are unaffected.
  - The phase toggles every 8 cycles.
- dp and invalid code: dp_in = 4'b0010, nibble 1 = 4'hA → digit 1 smg = 8'b0111_1111; other digits have bit7 = 1.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scan driver with double-buffered data, blink and leading-zero blanking
module seg_scan_driver #(
   parameter int DIGITS = 4,
   parameter int SCAN_DIV = 50000,
   parameter int BLINK_DIV = 12500000,
   parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] data_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blink_mask,
   input  logic                lz_blank_en,
   input  logic                load,
   output logic [DIGITS-1:0]   dig,
   output logic [7:0]          smg,
   output logic                frame_done
);
   localparam int IW = $clog2(DIGITS);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{~DIG_ACTIVE_HIGH}};

   logic [SW-1:0]       scan_cnt;
   logic [IW-1:0]       idx;
   logic [BW-1:0]       blink_cnt;
   logic                blink_on;
   logic [4*DIGITS-1:0] pend_data, disp_data;
   logic [DIGITS-1:0]   pend_dp, disp_dp;
   logic                pend_valid;
   logic                scan_wrap, frame_wrap, blink_wrap, blink_off, nz;
   logic [DIGITS-1:0]   blank, dig_next;
   logic [3:0]          nib;
   logic [7:0]          smg_next;

   function automatic logic [6:0] seg_code(input logic [3:0] n);
      case (n)
         4'd0: seg_code = 7'b000_0001;
         4'd1: seg_code = 7'b100_1111;
         4'd2: seg_code = 7'b001_0010;
         4'd3: seg_code = 7'b000_0110;
         4'd4: seg_code = 7'b100_1100;
         4'd5: seg_code = 7'b010_0100;
         4'd6: seg_code = 7'b010_0000;
         4'd7: seg_code = 7'b000_1111;
         4'd8: seg_code = 7'b000_0000;
         4'd9: seg_code = 7'b000_0100;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   assign scan_wrap  = scan_cnt == SCAN_LAST;
   assign frame_wrap = scan_wrap && idx == IDX_LAST;
   assign blink_wrap = blink_cnt == BLINK_LAST;
   assign frame_done = frame_wrap && !rst;

   // scan slot timing, digit index and free-running blink phase
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
         idx       <= scan_wrap ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
         blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
         blink_on  <= blink_wrap ? ~blink_on : blink_on;
      end
   end

   // pending capture; the display buffer only changes at a frame boundary, using the old pending contents
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         disp_data  <= '0;
         disp_dp    <= '0;
      end else begin
         if (frame_wrap && pend_valid) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
         end
         if (load) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
         end
         pend_valid <= load || (pend_valid && !frame_wrap);
      end
   end

   // leading-zero map: a digit blanks while every nibble from the top down to it is zero; digit 0 never blanks
   always_comb begin
      nz    = 1'b0;
      blank = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         nz       = nz | (|disp_data[4*i +: 4]);
         blank[i] = ~nz;
      end
   end

   assign nib       = disp_data[{idx, 2'b00} +: 4];
   assign blink_off = blink_mask[idx] && !blink_on;
   assign dig_next  = blink_off ? DIG_OFF : DIG_OFF ^ (DIGITS'(1) << idx);
   assign smg_next  = (blink_off || (lz_blank_en && blank[idx])) ? 8'hFF : {~disp_dp[idx], seg_code(nib)};

   // registered pin drivers, one cycle behind the digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         dig <= DIG_OFF;
         smg <= 8'hFF;
      end else begin
         dig <= dig_next;
         smg <= smg_next;
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench with a cycle-count reference model of the scan driver
module tb_seg_scan_driver;
   localparam int DIGITS = 4;
   localparam int SCAN_DIV = 4;
   localparam int BLINK_DIV = 8;
   localparam int FRAME = SCAN_DIV * DIGITS;
   localparam logic [6:0] SEG [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100,
                                       7'b010_0100, 7'b010_0000, 7'b000_1111, 7'b000_0000, 7'b000_0100};

   typedef struct packed {
      logic [3:0] dig;
      logic [7:0] smg;
      logic       fd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] data_in = '0;
   logic [3:0] dp_in = '0;
   logic [3:0] blink_mask = '0;
   logic lz_blank_en = 1'b0;
   logic load = 1'b0;
   logic [3:0] dig;
   logic [7:0] smg;
   logic frame_done;
   exp_t q[$];
   int checks = 0;
   int errors = 0;

   seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .DIG_ACTIVE_HIGH(1'b1)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blink_mask(blink_mask),
      .lz_blank_en(lz_blank_en), .load(load), .dig(dig), .smg(smg), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // reference model: time since reset decides slot and blink phase; buffers swap every FRAME cycles
   initial begin : model
      int k;
      int slot;
      bit on, blanked, pv;
      logic [15:0] pd, dd;
      logic [3:0] pp, mdp, n;
      exp_t e;
      k = 0; pv = 0; pd = '0; dd = '0; pp = '0; mdp = '0;
      forever begin
         @(posedge clk);
         e = '0;
         if (rst) begin
            k = 0; pv = 0; pd = '0; dd = '0; pp = '0; mdp = '0;
            e.dig = 4'b0000;
            e.smg = 8'hFF;
            e.fd = 1'b0;
         end else begin
            slot = (k / SCAN_DIV) % DIGITS;
            on = ((k / BLINK_DIV) % 2) == 0;
            n = dd[slot*4 +: 4];
            blanked = lz_blank_en && slot != 0 && (dd >> (4 * slot)) == 16'd0;
            if (blink_mask[slot] && !on) begin
               e.dig = 4'b0000;
               e.smg = 8'hFF;
            end else begin
               e.dig = 4'b0001 << slot;
               e.smg = blanked ? 8'hFF : {~mdp[slot], (n < 4'd10) ? SEG[int'(n)] : 7'h7F};
            end
            if (k % FRAME == FRAME - 1 && pv) begin
               dd = pd;
               mdp = pp;
               pv = 0;
            end
            if (load) begin
               pd = data_in;
               pp = dp_in;
               pv = 1;
            end
            k++;
            e.fd = (k % FRAME) == FRAME - 1;
         end
         q.push_back(e);
      end
   end

   // monitor: compare every presented cycle against the oldest expected entry
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (dig !== e.dig) begin
               errors++;
               $display("FAIL dig t=%0t got %b exp %b", $time, dig, e.dig);
            end
            checks++;
            if (smg !== e.smg) begin
               errors++;
               $display("FAIL smg t=%0t got %b exp %b", $time, smg, e.smg);
            end
            checks++;
            if (frame_done !== (e.fd && !rst)) begin
               errors++;
               $display("FAIL frame_done t=%0t got %b exp %b", $time, frame_done, e.fd && !rst);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      load = 1'b1;
      data_in = d;
      dp_in = p;
      step(1);
      load = 1'b0;
   endtask

   // stimulus: directed scenarios first, then randomized traffic with occasional mid-frame resets
   initial begin : stim
      step(3);
      rst = 1'b0;
      step(2);
      do_load(16'h1234, 4'b0000);
      step(40);
      step(5);
      do_load(16'h5678, 4'b0000);
      step(40);
      do_load(16'h0040, 4'b0000);
      step(3);
      do_load(16'h9A05, 4'b1001);
      step(40);
      lz_blank_en = 1'b1;
      do_load(16'h0040, 4'b0000);
      step(40);
      do_load(16'h0000, 4'b0000);
      step(40);
      lz_blank_en = 1'b0;
      step(20);
      blink_mask = 4'b0100;
      step(40);
      blink_mask = 4'b0000;
      do_load(16'h00A0, 4'b0010);
      step(40);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(299) == 0);
         load = ($urandom_range(7) == 0);
         for (int j = 0; j < 4; j++)
            data_in[4*j +: 4] = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
         dp_in = 4'($urandom);
         if ($urandom_range(49) == 0) blink_mask = 4'($urandom);
         if ($urandom_range(49) == 0) lz_blank_en = 1'($urandom);
         step(1);
      end
      rst = 1'b0;
      load = 1'b0;
      step(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
